// File: rtl/jt7759_romfeed.sv
// Two-line prefetching byte buffer between the JT7759 ROM request port and a
// 16-bit cs/ok memory port. Lines are 4 words (8 bytes), filled word 0 to 3.
module jt7759_romfeed #(
    parameter int unsigned PREFETCH = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        rom_cs,
    input  logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_ok,
    input  logic        flush,
    output logic        mem_cs,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ok
);

    localparam int unsigned TW    = 14;
    localparam int unsigned DW    = 16;
    localparam int unsigned NWORD = 4;
    localparam int unsigned NBUF  = 2;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    logic [TW-1:0]    tag [NBUF];
    logic [NBUF-1:0]  lv;
    logic [NWORD-1:0] wv  [NBUF];
    logic [DW-1:0]    dat [NBUF][NWORD];
    logic             lru;
    state_t           state;
    logic             fbuf;
    logic [1:0]       wcnt;
    logic             abort_q;

    logic [TW-1:0]    req_tag;
    logic [1:0]       req_word;
    logic [NBUF-1:0]  match;
    logic [NBUF-1:0]  whit;
    logic             hit;
    logic             hit_buf;
    logic             demand_miss;
    logic [TW-1:0]    pf_tag;
    logic             pf_need;
    logic             victim;
    logic             start_go;
    logic [TW-1:0]    start_tag;
    logic [DW-1:0]    hit_word;
    logic [7:0]       hit_byte;

    // Lookup: a line matching the tag counts as present even while still filling
    always_comb begin
        req_tag  = rom_addr[16:3];
        req_word = rom_addr[2:1];
        match    = '0;
        whit     = '0;
        for (int i = 0; i < int'(NBUF); i++) begin
            match[i] = lv[i] && (tag[i] == req_tag);
            whit[i]  = match[i] && wv[i][req_word];
        end
        hit         = rom_cs && (|whit);
        hit_buf     = whit[1];
        demand_miss = rom_cs && !(|match);
        pf_tag      = tag[lru] + TW'(1);
        pf_need     = (PREFETCH != 0) && lv[lru]
                      && !(lv[0] && (tag[0] == pf_tag))
                      && !(lv[1] && (tag[1] == pf_tag));
        victim      = ~lru;
        start_go    = !flush && (demand_miss || pf_need);
        start_tag   = demand_miss ? req_tag : pf_tag;
        hit_word    = dat[hit_buf][req_word];
        hit_byte    = rom_addr[0] ? hit_word[15:8] : hit_word[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_ok   <= 1'b0;
            rom_data <= '0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            lv       <= '0;
            lru      <= 1'b0;
            state    <= IDLE;
            fbuf     <= 1'b0;
            wcnt     <= '0;
            abort_q  <= 1'b0;
            for (int i = 0; i < int'(NBUF); i++) begin
                tag[i] <= '0;
                wv[i]  <= '0;
                for (int j = 0; j < int'(NWORD); j++) begin
                    dat[i][j] <= '0;
                end
            end
        end else begin
            rom_ok <= hit && !flush;
            if (hit && !flush) begin
                rom_data <= hit_byte;
                lru      <= hit_buf;
            end
            if (flush) begin
                lv <= '0;
                for (int i = 0; i < int'(NBUF); i++) begin
                    wv[i] <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (start_go) begin
                        fbuf        <= victim;
                        tag[victim] <= start_tag;
                        lv[victim]  <= 1'b1;
                        wv[victim]  <= '0;
                        wcnt        <= '0;
                        abort_q     <= 1'b0;
                        mem_cs      <= 1'b1;
                        mem_addr    <= {start_tag, 2'b00};
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        // An outstanding word must still be drained before going idle
                        if (mem_cs && !mem_ok) begin
                            state <= DRAIN;
                        end else begin
                            mem_cs <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (mem_cs) begin
                        if (mem_ok) begin
                            mem_cs          <= 1'b0;
                            dat[fbuf][wcnt] <= mem_data;
                            wv[fbuf][wcnt]  <= 1'b1;
                            wcnt            <= wcnt + 2'd1;
                            if (abort_q || demand_miss) begin
                                lv[fbuf] <= 1'b0;
                                state    <= IDLE;
                            end else if (wcnt == 2'd3) begin
                                state <= IDLE;
                            end
                        end else if (demand_miss) begin
                            abort_q <= 1'b1;
                        end
                    end else if (abort_q || demand_miss) begin
                        lv[fbuf] <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        mem_cs   <= 1'b1;
                        mem_addr <= {tag[fbuf], wcnt};
                    end
                end
                DRAIN: begin
                    if (mem_ok) begin
                        mem_cs <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt7759_romfeed.sv
// Directed bench for jt7759_romfeed with a fixed-latency 16-bit memory model.
module tb_jt7759_romfeed;

    localparam logic [16:0] NO_HOLD = 17'h10000;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rom_cs   = 1'b0;
    logic [16:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        flush    = 1'b0;
    logic        mem_cs;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        mem_ok   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          mem_lat   = 3;
    int          mem_wait  = 0;
    logic        prev_cs   = 1'b0;
    logic [16:0] hold_addr = NO_HOLD;
    logic [15:0] log_addr[$];
    int          log_cyc[$];
    int          rise_cyc[$];

    jt7759_romfeed #(.PREFETCH(1)) dut (
        .rst      (rst),
        .clk      (clk),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .flush    (flush),
        .mem_cs   (mem_cs),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ok   (mem_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_val(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
    endfunction

    function automatic logic [15:0] word_val(input logic [15:0] w);
        return {byte_val({w, 1'b1}), byte_val({w, 1'b0})};
    endfunction

    // Memory: answers mem_cs after mem_lat cycles; hold_addr stalls one word address
    always @(negedge clk) begin
        if (mem_cs && !prev_cs) rise_cyc.push_back(cyc);
        prev_cs = mem_cs;
        if (mem_ok) begin
            mem_ok = 1'b0;
        end else if (mem_cs && ({1'b0, mem_addr} != hold_addr)) begin
            mem_wait++;
            if (mem_wait >= mem_lat) begin
                mem_ok   = 1'b1;
                mem_data = word_val(mem_addr);
                mem_wait = 0;
                log_addr.push_back(mem_addr);
                log_cyc.push_back(cyc);
            end
        end else if (!mem_cs) begin
            mem_wait = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs;
        log_addr.delete();
        log_cyc.delete();
        rise_cyc.delete();
    endtask

    task automatic read_byte(input logic [16:0] a, input int maxw,
                             output int lat, output logic [7:0] d);
        rom_addr = a;
        rom_cs   = 1'b1;
        lat      = -1;
        d        = 8'h00;
        for (int n = 1; n <= maxw; n++) begin
            @(negedge clk);
            if (rom_ok) begin
                lat = n;
                d   = rom_data;
                break;
            end
        end
    endtask

    // Drop requests, flush and wait for the memory port to go quiet
    task automatic settle(input string name);
        int run;
        bit ok;
        rom_cs = 1'b0;
        flush  = 1'b1;
        tick(1);
        flush  = 1'b0;
        run = 0;
        ok  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            run = mem_cs ? 0 : run + 1;
            if (run >= 12) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_settle: mem port still busy after 1000 cycles", name);
        end
        clear_logs();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        total++; if (rom_ok !== 1'b0)     begin bad++; $display("FAIL reset_rom_ok: got %b want 0", rom_ok); end
        total++; if (rom_data !== 8'h00)  begin bad++; $display("FAIL reset_rom_data: got %h want 00", rom_data); end
        total++; if (mem_cs !== 1'b0)     begin bad++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
        total++; if (mem_addr !== 16'h0)  begin bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        rst = 1'b0;
        tick(4);
        total++; if (mem_cs !== 1'b0 || rom_ok !== 1'b0) begin
            bad++; $display("FAIL reset_idle: mem_cs=%b rom_ok=%b want 0 0", mem_cs, rom_ok);
        end
    endtask

    task automatic test_cold_miss;
        int c0, lat, okc;
        logic [7:0] d;
        logic [15:0] a;
        clear_logs();
        c0 = cyc;
        read_byte(17'h00005, 60, lat, d);
        okc = cyc;
        for (int i = 0; i < 60 && log_addr.size() < 4; i++) tick(1);
        total++; if (d !== byte_val(17'h00005)) begin
            bad++; $display("FAIL cold_data: got %h want %h (lat %0d)", d, byte_val(17'h00005), lat);
        end
        total++; if ((rise_cyc.size() > 0 ? rise_cyc[0] : -1) != c0 + 1) begin
            bad++; $display("FAIL cold_mem_cs_latency: got cycle %0d want %0d",
                            rise_cyc.size() > 0 ? rise_cyc[0] : -1, c0 + 1);
        end
        for (int i = 0; i < 4; i++) begin
            a = (log_addr.size() > i) ? log_addr[i] : 16'hDEAD;
            total++; if (a !== 16'(i)) begin
                bad++; $display("FAIL cold_order_%0d: mem_addr got %h want %h", i, a, 16'(i));
            end
        end
        total++; if (okc != (log_cyc.size() > 2 ? log_cyc[2] : -100) + 2) begin
            bad++; $display("FAIL cold_ok_timing: rom_ok at cycle %0d want %0d",
                            okc, (log_cyc.size() > 2 ? log_cyc[2] : -100) + 2);
        end
        settle("cold");
    endtask

    task automatic test_stream;
        int lat;
        logic [7:0] d;
        logic [15:0] a;
        for (int i = 0; i < 32; i++) begin
            read_byte(17'(i), 60, lat, d);
            total++; if (d !== byte_val(17'(i))) begin
                bad++; $display("FAIL stream_data_%0d: got %h want %h", i, d, byte_val(17'(i)));
            end
            if (i >= 8) begin
                total++; if (lat < 1 || lat > 2) begin
                    bad++; $display("FAIL stream_hit_latency_%0d: got %0d want 1..2", i, lat);
                end
            end
            rom_cs = 1'b0;
            tick(6);
        end
        for (int i = 0; i < 16; i++) begin
            a = (log_addr.size() > i) ? log_addr[i] : 16'hDEAD;
            total++; if (a !== 16'(i)) begin
                bad++; $display("FAIL stream_order_%0d: mem_addr got %h want %h", i, a, 16'(i));
            end
        end
        total++; if ((rise_cyc.size() > 4 ? rise_cyc[4] : -1) != (log_cyc.size() > 3 ? log_cyc[3] : -100) + 2) begin
            bad++; $display("FAIL stream_prefetch_start: got cycle %0d want %0d",
                            rise_cyc.size() > 4 ? rise_cyc[4] : -1,
                            (log_cyc.size() > 3 ? log_cyc[3] : -100) + 2);
        end
        settle("stream");
    endtask

    task automatic test_wrap;
        int lat;
        logic [7:0] d;
        logic [16:0] ba;
        logic [15:0] a, e;
        for (int i = 0; i < 8; i++) begin
            ba = 17'h1FFF8 + 17'(i);
            read_byte(ba, 60, lat, d);
            total++; if (d !== byte_val(ba)) begin
                bad++; $display("FAIL wrap_data_%0d: got %h want %h", i, d, byte_val(ba));
            end
            rom_cs = 1'b0;
            tick(2);
        end
        for (int i = 0; i < 100 && log_addr.size() < 8; i++) tick(1);
        for (int i = 0; i < 8; i++) begin
            e = (i < 4) ? 16'hFFFC + 16'(i) : 16'(i - 4);
            a = (log_addr.size() > i) ? log_addr[i] : 16'hDEAD;
            total++; if (a !== e) begin
                bad++; $display("FAIL wrap_order_%0d: mem_addr got %h want %h", i, a, e);
            end
        end
        settle("wrap");
    endtask

    task automatic test_flush_pending;
        int lat;
        logic [7:0] d;
        bit seen, held;
        logic [15:0] a0, a1;
        hold_addr = 17'h00081;
        read_byte(17'h00100, 60, lat, d);
        total++; if (lat < 1 || d !== byte_val(17'h00100)) begin
            bad++; $display("FAIL flush_pre_hit: lat %0d data %h want data %h", lat, d, byte_val(17'h00100));
        end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_cs && mem_addr == 16'h0081) begin seen = 1'b1; break; end
            tick(1);
        end
        total++; if (!seen) begin bad++; $display("FAIL flush_reach_word1: mem_addr %h never pending", 16'h0081); end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        clear_logs();
        total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL flush_beats_hit: rom_ok got %b want 0", rom_ok); end
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (!(mem_cs && mem_addr == 16'h0081) || rom_ok) held = 1'b0;
        end
        total++; if (!held) begin
            bad++; $display("FAIL flush_drain_hold: mem_cs=%b mem_addr=%h rom_ok=%b want 1 0081 0", mem_cs, mem_addr, rom_ok);
        end
        hold_addr = NO_HOLD;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (rom_ok) begin lat = n; d = rom_data; break; end
        end
        total++; if (lat < 0 || d !== byte_val(17'h00100)) begin
            bad++; $display("FAIL flush_refetch_data: lat %0d data %h want %h", lat, d, byte_val(17'h00100));
        end
        a0 = (log_addr.size() > 0) ? log_addr[0] : 16'hDEAD;
        a1 = (log_addr.size() > 1) ? log_addr[1] : 16'hDEAD;
        total++; if (a0 !== 16'h0081 || a1 !== 16'h0080) begin
            bad++; $display("FAIL flush_refetch_order: got %h,%h want 0081,0080", a0, a1);
        end
        settle("flush");
    endtask

    task automatic test_abort;
        int lat, idx;
        logic [7:0] d;
        bit seen, held;
        logic [15:0] nxt, prv;
        hold_addr = 17'h00009;
        read_byte(17'h00008, 60, lat, d);
        total++; if (d !== byte_val(17'h00008)) begin
            bad++; $display("FAIL abort_first_data: got %h want %h", d, byte_val(17'h00008));
        end
        rom_cs = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (mem_cs && mem_addr == 16'h0009) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL abort_prefetch_seen: mem_addr 0009 never pending"); end
        rom_addr = 17'h10000;
        rom_cs   = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (!(mem_cs && mem_addr == 16'h0009)) held = 1'b0;
        end
        total++; if (!held) begin
            bad++; $display("FAIL abort_cs_held: mem_cs=%b mem_addr=%h want 1 0009", mem_cs, mem_addr);
        end
        hold_addr = NO_HOLD;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (rom_ok) begin lat = n; d = rom_data; break; end
        end
        total++; if (lat < 0 || d !== byte_val(17'h10000)) begin
            bad++; $display("FAIL abort_demand_data: lat %0d data %h want %h", lat, d, byte_val(17'h10000));
        end
        idx = -1;
        foreach (log_addr[i]) if (log_addr[i] == 16'h0009 && idx < 0) idx = i;
        nxt = (idx >= 0 && log_addr.size() > idx + 1) ? log_addr[idx + 1] : 16'hDEAD;
        prv = (idx >= 1) ? log_addr[idx - 1] : 16'hDEAD;
        total++; if (nxt !== 16'h8000 || prv !== 16'h0008) begin
            bad++; $display("FAIL abort_next_addr: around 0009 got %h,%h want 0008,8000", prv, nxt);
        end
        settle("abort");
        read_byte(17'h00010, 60, lat, d);
        total++; if (lat <= 2 || d !== byte_val(17'h00010) || (log_addr.size() > 0 ? log_addr[0] : 16'hDEAD) !== 16'h0008) begin
            bad++; $display("FAIL abort_buffer_invalid: lat %0d data %h first %h want >2 %h 0008",
                            lat, d, log_addr.size() > 0 ? log_addr[0] : 16'hDEAD, byte_val(17'h00010));
        end
        settle("abort2");
    endtask

    task automatic test_reset_midfill;
        int lat;
        logic [7:0] d;
        bit seen;
        hold_addr = 17'h00022;
        read_byte(17'h00040, 60, lat, d);
        total++; if (d !== byte_val(17'h00040)) begin
            bad++; $display("FAIL rst_pre_data: got %h want %h", d, byte_val(17'h00040));
        end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_cs && mem_addr == 16'h0022) begin seen = 1'b1; break; end
            tick(1);
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_reach_word2: mem_addr 0022 never pending"); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (rom_ok !== 1'b0)    begin bad++; $display("FAIL rst_async_rom_ok: got %b want 0", rom_ok); end
        total++; if (rom_data !== 8'h00) begin bad++; $display("FAIL rst_async_rom_data: got %h want 00", rom_data); end
        total++; if (mem_cs !== 1'b0)    begin bad++; $display("FAIL rst_async_mem_cs: got %b want 0", mem_cs); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_async_mem_addr: got %h want 0000", mem_addr); end
        tick(1);
        hold_addr = NO_HOLD;
        clear_logs();
        rst = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            tick(1);
            if (rom_ok) begin lat = n; d = rom_data; break; end
        end
        total++; if (lat <= 2 || d !== byte_val(17'h00040)) begin
            bad++; $display("FAIL rst_miss_after: lat %0d data %h want >2 %h", lat, d, byte_val(17'h00040));
        end
        total++; if ((log_addr.size() > 0 ? log_addr[0] : 16'hDEAD) !== 16'h0020) begin
            bad++; $display("FAIL rst_refetch_addr: got %h want 0020", log_addr.size() > 0 ? log_addr[0] : 16'hDEAD);
        end
        settle("rst");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_stream();
        test_wrap();
        test_flush_pending();
        test_abort();
        test_reset_midfill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jt7759_romfeed.md
# jt7759_romfeed

ROM-side responder for the JT7759 controller's `rom_cs`/`rom_addr`/`rom_data`/`rom_ok` request interface. It serves byte requests from a two-line, 8-byte-per-line buffer, which it fills from a 16-bit external memory port (SDRAM-style `cs`/`ok` handshake). It prefetches the next sequential line, so ADPCM streaming sees hits. It sits between the sound controller and the system memory arbiter.

## Interface
- PREFETCH, 1, enable sequential next-line prefetch (0 = demand fetch only)
- rst  in  1  asynchronous, active-high reset
- clk  in  1  clock
- rom_cs  in  1  byte request; may drop for single cycles between addresses
- rom_addr  in  17  byte address
- rom_data  out  8  byte for the request
- rom_ok  out  1  rom_data valid for the current rom_addr
- flush  in  1  one-cycle pulse; invalidate all buffered data
- mem_cs  out  1  word request, held until mem_ok
- mem_addr  out  16  word address (byte address [16:1])
- mem_data  in  16  word; byte addr[0]=0 → [7:0], addr[0]=1 → [15:8]
- mem_ok  in  1  mem_data valid; ends the transaction

## Operation
- Line: 4 words, tag = addr[16:3], word = addr[2:1]. Each of the 2 buffers holds a tag, a line-valid bit and a 4-bit word-valid mask.
- Hit: rom_cs=1, some buffer has tag==rom_addr[16:3] and word-valid set. On a hit, mark that buffer most-recently-used (lru bit).
- Output register, every clk:
  - rom_ok ← rom_cs & hit.
  - rom_data ← selected byte on hit; otherwise rom_data holds its value.
- Fill FSM states:
  - IDLE
  - FILL: buf, wcnt 0..3, tag
  - DRAIN: finish the outstanding word and discard it
- Fill order: always words 0→3 of the line. mem_addr = {tag, wcnt}. On mem_ok, write the word and set its valid bit. wcnt==3 ends the fill → IDLE.
- Each line fill issues its 4 word requests as 4 separate mem_cs/mem_ok transactions.
- IDLE priority:
  - First, a demand miss (rom_cs=1, no tag match in either buffer): fill victim = ~lru.
  - Second, if PREFETCH: the line tag_lru+1 (17-bit address space, wraps 0x3FFF→0) is not present → fill the non-lru buffer.
  - Otherwise stay idle.
- Starting a fill clears the target buffer's word mask and loads the new tag before the first mem_cs.
- Demand miss during FILL:
  - Address inside the line being filled: wait; it hits when its word arrives.
  - Any other line: abort after the outstanding mem_ok, invalidate the partial buffer, then start the demand fill.
- mem_cs never drops before mem_ok. Only one transaction is outstanding at a time.
- flush:
  - Clears all valid bits and rom_ok the next cycle.
  - In FILL: go to DRAIN, hold mem_cs until mem_ok, discard the data, then IDLE.
  - flush in IDLE takes effect immediately.
- rom_cs low: no demand, but prefetch may proceed.

## Timing
- Reset values:
  - Outputs: rom_ok=0, rom_data=0, mem_cs=0, mem_addr=0.
  - Internal: all valid bits 0, lru=0, FSM IDLE.
- Hit latency: request seen at edge N → rom_ok=1 after edge N+1. Address change with rom_cs held high: rom_ok is recomputed on the next edge and is never stale for more than 1 cycle; the controller's cs gap guarantees it samples the new value.
- Miss latency: mem_cs asserted 1 cycle after the miss is seen in IDLE. The word becomes hit-able the cycle after mem_ok; rom_ok follows 1 cycle later.
- mem_cs deasserts in the cycle after mem_ok. The next word request is issued immediately (1-cycle gap).
- Simultaneous events:
  - flush together with a hit: flush wins, rom_ok=0.
  - flush together with mem_ok: the word is discarded → IDLE.
  - A hit and a fill-complete in the same cycle both apply.
- Reset mid-transaction: drop mem_cs immediately. The memory side must tolerate an abandoned request.

## Test plan
- Cold miss: rom_cs=1, addr 0x00005 → mem_addr 0x0000,1,2,3 in order; rom_ok=1 with rom_data = high byte of word 0x0002, 2 cycles after that word's mem_ok.
- Sequential stream 0x00000–0x0001F, mem_ok latency 3 cycles, PREFETCH=1 → after the first line, every request hits within 2 cycles. Prefetch of line 0x0008 starts right after line 0x0000 completes.
- Wrap: read 0x1FFF8–0x1FFFF → prefetch fetches mem_addr 0x0000–0x0003.
- flush while mem_cs is pending on word 1 → mem_cs held until mem_ok, data discarded. The following read of the same address misses and refetches from word 0.
- Miss to 0x10000 during a prefetch of 0x00010 → the prefetch aborts after the current word; the next mem_addr is 0x8000; the aborted buffer is invalid.
- Async rst asserted mid-fill → all outputs 0 that cycle; after release, a previously filled address misses.
